next_pc_gen: RTL and testbench
==============================

NEXT_PC_GEN -- requirements
Module: next_pc_gen

Interface
REQ-001 Parameter XLEN, default 32, datapath width of all addresses and operands (legal values 32, 64).
REQ-002 Parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-003 Parameter TRAP_VEC, default 32'h0000_0100, PC value loaded on a trap.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 pc_ready  in  1  instruction memory accepts pc_out this cycle.
REQ-007 stall  in  1  pipeline hold; the PC does not advance.
REQ-008 br_en  in  1  current instruction is a conditional branch.
REQ-009 br_op  in  3  branch compare, RISC-V funct3: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; 010/011 never taken.
REQ-010 rs1, rs2  in  XLEN  branch compare operands; rs1 is also the jalr base.
REQ-011 imm  in  XLEN  sign-extended offset.
REQ-012 jal, jalr  in  1  unconditional jump, PC-relative or register-based.
REQ-013 trap_req  in  1  exception/interrupt request, single-cycle pulse.
REQ-014 mret  in  1  return from trap.
REQ-015 pc_out  out  XLEN  current instruction address.
REQ-016 pc_valid  out  1  pc_out is a valid fetch address.
REQ-017 link  out  XLEN  pc_out + 4, combinational, used as the jal/jalr return value.
REQ-018 taken  out  1  combinational; a non-sequential redirect would be selected this cycle.
REQ-019 epc  out  XLEN  saved trap PC.
REQ-020 misalign_err  out  1  one-cycle pulse on a misaligned target (see REQ-036).

Function
REQ-021 Define advance = pc_valid & pc_ready & ~stall; pc_out, epc and the state machine change only on an advance edge, except as stated in REQ-025 and REQ-026.
REQ-022 On advance, next PC priority: trap (trap_req or TRAP_PEND) -> TRAP_VEC; else mret -> epc; else jalr -> (rs1+imm) with bit0 cleared; else jal -> pc_out+imm; else br_en and compare true -> pc_out+imm; else pc_out+4.
REQ-023 Compare: lt/ge signed XLEN, ltu/geu unsigned; all arithmetic modulo 2^XLEN, so pc_out = 2^XLEN-4 advances to 0.
REQ-024 States: IDLE (pc_valid=0), RUN (pc_valid=1), TRAP_PEND (pc_valid=1, trap latched).
REQ-025 IDLE -> RUN on the first clock edge after reset release; pc_out holds RESET_VEC and all decode inputs are ignored in IDLE.
REQ-026 In RUN, trap_req without advance -> TRAP_PEND (latched even while pc_ready=0 or stall=1); trap_req with advance is taken directly and the state stays RUN.
REQ-027 TRAP_PEND -> RUN on the next advance, which loads TRAP_VEC; further trap_req pulses while pending are merged.
REQ-028 On a taken trap, epc <= pc_out (the address of the interrupted instruction) on the same edge.
REQ-029 mret and trap on the same advance: the trap wins, epc <= pc_out, and mret is discarded.
REQ-030 When advance=0, decode inputs (br_en, jal, jalr, mret) are ignored and not latched; the issuing stage re-presents them.
REQ-031 taken = jal | jalr | mret | trap_req | TRAP_PEND | (br_en & compare); it is valid only in RUN/TRAP_PEND and is 0 in IDLE.
REQ-032 Latency: a redirect decided on an advance edge appears on pc_out in the following cycle; there are no bubbles.

Reset
REQ-033 While rst_n=0: pc_out=RESET_VEC, epc=0, pc_valid=0, misalign_err=0, state=IDLE, asynchronously.
REQ-034 Reset asserted mid-operation, including in TRAP_PEND, discards any pending trap immediately.
REQ-035 Reset removal is synchronised by the first clk edge; pc_valid rises exactly one edge later.

Configuration
REQ-036 Macro NPC_MISALIGN_TRAP_EN, when defined: a selected jal/branch/jalr target with bits[1:0] != 0 redirects to TRAP_VEC instead; epc <= pc_out and misalign_err pulses for one cycle.
REQ-037 Without NPC_MISALIGN_TRAP_EN: target bits[1:0] are forced to 00, misalign_err is tied 0, and no trap is generated.

Verification
REQ-038 Reset, release, pc_ready=1 with no decode -> pc_valid 0 then 1; pc_out 0, 4, 8.
REQ-039 pc_out=0x10, br_en=1, br_op=100, rs1=0xFFFFFFFF, rs2=1, imm=0x20 -> taken (signed); next pc_out=0x30; with br_op=110 -> not taken, next pc_out=0x14.
REQ-040 pc_out=0x40, jalr, rs1=0x103, imm=0 -> link=0x44; next pc_out=0x100 (macro off) or TRAP_VEC with misalign_err=1 and epc=0x40 (macro on).
REQ-041 pc_out=0x80, pc_ready=0, trap_req pulse, then pc_ready=1 after 3 cycles -> TRAP_PEND held; next pc_out=0x100, epc=0x80; a following mret -> pc_out=0x80.
REQ-042 XLEN=32, pc_out=0xFFFFFFFC, no decode -> next pc_out=0x0; stall=1 for 2 cycles with jal asserted -> pc_out held and the jal ignored.
REQ-043 rst_n asserted in TRAP_PEND -> pc_out=RESET_VEC, pc_valid=0, and no trap taken after release.

Source files
------------

// File: rtl/next_pc_gen.sv
// next_pc_gen: fetch PC sequencer with branch/jump/mret/trap redirects and an IDLE/RUN/TRAP_PEND FSM.
// Define NPC_MISALIGN_TRAP_EN to trap on misaligned jump/branch targets instead of clearing bits[1:0].
module next_pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_ready,
    input  logic            stall,
    input  logic            br_en,
    input  logic [2:0]      br_op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    input  logic            jal,
    input  logic            jalr,
    input  logic            trap_req,
    input  logic            mret,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic [XLEN-1:0] link,
    output logic            taken,
    output logic [XLEN-1:0] epc,
    output logic            misalign_err
);
    typedef enum logic [1:0] {IDLE, RUN, TRAP_PEND} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, epc_q, tgt_raw, target;
    logic            misalign_q, advance, trap_pend, trap_now, cmp, redir, mis;
    logic            eq, lt, ltu;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;

    always_comb
        state_d = state_q == IDLE ? RUN :
                  state_q == RUN  ? ((trap_req & ~advance) ? TRAP_PEND : RUN) :
                  (advance ? RUN : TRAP_PEND);

    always_comb begin
        pc_valid  = state_q != IDLE;
        trap_pend = state_q == TRAP_PEND;
    end

    assign advance  = pc_valid & pc_ready & ~stall;
    assign trap_now = trap_req | trap_pend;

    assign eq  = rs1 == rs2;
    assign lt  = $signed(rs1) < $signed(rs2);
    assign ltu = rs1 < rs2;
    // funct3[0] inverts the base compare; 010/011 are never taken
    assign cmp = br_op[2] ? ((br_op[1] ? ltu : lt) ^ br_op[0]) : (~br_op[1] & (eq ^ br_op[0]));

    assign redir   = jal | jalr | (br_en & cmp);
    assign tgt_raw = jalr ? ((rs1 + imm) & ~XLEN'(1)) : pc_q + imm;

`ifdef NPC_MISALIGN_TRAP_EN
    assign target = tgt_raw;
    assign mis    = redir & ~trap_now & ~mret & (|tgt_raw[1:0]);
`else
    assign target = {tgt_raw[XLEN-1:2], 2'b00};
    assign mis    = 1'b0;
`endif

    assign pc_d = (trap_now | mis) ? TRAP_VEC :
                  mret             ? epc_q    :
                  redir            ? target   : pc_q + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pc_q       <= RESET_VEC;
            epc_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= advance & mis;
            if (advance) begin
                pc_q <= pc_d;
                if (trap_now | mis) epc_q <= pc_q;
            end
        end

    assign pc_out       = pc_q;
    assign epc          = epc_q;
    assign misalign_err = misalign_q;
    assign link         = pc_q + XLEN'(4);
    assign taken        = pc_valid & (jal | jalr | mret | trap_now | (br_en & cmp));
endmodule

// File: tb/tb_next_pc_gen.sv
// tb_next_pc_gen: directed table, hand-written corner sequences and a randomized run against a reference model.
module tb_next_pc_gen;
    localparam logic [31:0] TRAP = 32'h100;

    logic        clk = 0, rst_n = 0, pc_ready = 1, stall = 0, br_en = 0, jal = 0, jalr = 0, trap_req = 0, mret = 0;
    logic [2:0]  br_op = 0;
    logic [31:0] rs1 = 0, rs2 = 0, imm = 0;
    logic [31:0] pc_out, link, epc;
    logic        pc_valid, taken, misalign_err;
    int          checks = 0, errors = 0;

    next_pc_gen dut (
        .clk(clk), .rst_n(rst_n), .pc_ready(pc_ready), .stall(stall), .br_en(br_en), .br_op(br_op),
        .rs1(rs1), .rs2(rs2), .imm(imm), .jal(jal), .jalr(jalr), .trap_req(trap_req), .mret(mret),
        .pc_out(pc_out), .pc_valid(pc_valid), .link(link), .taken(taken), .epc(epc), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        pc_ready = 1; stall = 0; br_en = 0; br_op = 0; rs1 = 0; rs2 = 0; imm = 0;
        jal = 0; jalr = 0; trap_req = 0; mret = 0;
    endtask

    typedef struct {
        bit rdy, stl, br;
        logic [2:0] op;
        logic [31:0] a, b, im;
        bit j, jr, tr, mr, tk;
        logic [31:0] pc, epc;
    } vec_t;

    function automatic vec_t mk(bit rdy, bit stl, bit br, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                                logic [31:0] im, bit j, bit jr, bit tr, bit mr, bit tk,
                                logic [31:0] pc, logic [31:0] ep);
        vec_t v;
        v.rdy = rdy; v.stl = stl; v.br = br; v.op = op; v.a = a; v.b = b; v.im = im;
        v.j = j; v.jr = jr; v.tr = tr; v.mr = mr; v.tk = tk; v.pc = pc; v.epc = ep;
        return v;
    endfunction

    function automatic bit cmp_f(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return $signed(a) < $signed(b);
            3'b101: return $signed(a) >= $signed(b);
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 0;
        endcase
    endfunction

    logic [31:0] m_pc, m_epc;
    bit          m_valid, m_pend, m_mis;

    function automatic void m_reset();
        m_pc = 0; m_epc = 0; m_valid = 0; m_pend = 0; m_mis = 0;
    endfunction

    function automatic bit m_taken();
        return m_valid && (jal || jalr || mret || trap_req || m_pend || (br_en && cmp_f(br_op, rs1, rs2)));
    endfunction

    function automatic void m_edge();
        bit adv, t, red, mis;
        logic [31:0] tgt;
        adv = m_valid && pc_ready && !stall;
        t   = trap_req || m_pend;
        red = jal || jalr || (br_en && cmp_f(br_op, rs1, rs2));
        tgt = jalr ? ((rs1 + imm) & ~32'd1) : m_pc + imm;
        mis = 0;
`ifdef NPC_MISALIGN_TRAP_EN
        mis = red && !t && !mret && (tgt % 4 != 0);
`else
        tgt = tgt - (tgt % 4);
`endif
        m_mis = adv && mis;
        if (!m_valid) m_valid = 1;
        else if (adv) begin
            if (t || mis) begin m_epc = m_pc; m_pc = TRAP; end
            else if (mret) m_pc = m_epc;
            else if (red) m_pc = tgt;
            else m_pc = m_pc + 4;
            m_pend = 0;
        end else if (trap_req) m_pend = 1;
    endfunction

    vec_t        tbl[17];
    logic [31:0] exp_pc, e7;

    initial begin
`ifdef NPC_MISALIGN_TRAP_EN
        e7 = 32'h40;
`else
        e7 = 32'h0;
`endif
        tbl[0]  = mk(1,0,0,0,0,0,0,                      0,0,0,0,0, 32'h4,   0);
        tbl[1]  = mk(1,0,0,0,0,0,0,                      0,0,0,0,0, 32'h8,   0);
        tbl[2]  = mk(1,0,0,0,0,0,32'h8,                  1,0,0,0,1, 32'h10,  0);
        tbl[3]  = mk(1,0,1,3'b100,32'hFFFFFFFF,1,32'h20, 0,0,0,0,1, 32'h30,  0);
        tbl[4]  = mk(1,0,0,0,0,0,32'hFFFFFFE0,           1,0,0,0,1, 32'h10,  0);
        tbl[5]  = mk(1,0,1,3'b110,32'hFFFFFFFF,1,32'h20, 0,0,0,0,0, 32'h14,  0);
        tbl[6]  = mk(1,0,1,3'b000,5,5,32'h2C,            0,0,0,0,1, 32'h40,  0);
        tbl[7]  = mk(1,0,0,0,32'h103,0,0,                0,1,0,0,1, 32'h100, e7);
        tbl[8]  = mk(1,0,1,3'b001,1,1,32'h40,            0,0,0,0,0, 32'h104, e7);
        tbl[9]  = mk(1,0,1,3'b010,1,2,32'h40,            0,0,0,0,0, 32'h108, e7);
        tbl[10] = mk(1,0,1,3'b101,32'hFFFFFFFF,1,32'h40, 0,0,0,0,0, 32'h10C, e7);
        tbl[11] = mk(1,0,1,3'b111,32'hFFFFFFFF,1,32'h10, 0,0,0,0,1, 32'h11C, e7);
        tbl[12] = mk(1,0,0,0,0,0,0,                      0,0,1,1,1, 32'h100, 32'h11C);
        tbl[13] = mk(1,0,0,0,0,0,0,                      0,0,0,1,1, 32'h11C, 32'h11C);
        tbl[14] = mk(1,1,0,0,0,0,32'h40,                 1,0,0,0,1, 32'h11C, 32'h11C);
        tbl[15] = mk(0,0,0,0,0,0,32'h40,                 1,0,0,0,1, 32'h11C, 32'h11C);
        tbl[16] = mk(1,0,0,0,0,0,0,                      0,0,0,0,0, 32'h120, 32'h11C);

        idle_in();
        #1;
        chk("rst_pc", pc_out, 0); chk("rst_valid", pc_valid, 0); chk("rst_epc", epc, 0);
        chk("rst_mis", misalign_err, 0); chk("rst_taken", taken, 0);
        tick(); tick();
        @(negedge clk) rst_n = 1;
        #1 chk("rel_valid_pre", pc_valid, 0);
        tick();
        chk("rel_valid", pc_valid, 1); chk("rel_pc", pc_out, 0);

        exp_pc = 0;
        foreach (tbl[i]) begin
            pc_ready = tbl[i].rdy; stall = tbl[i].stl; br_en = tbl[i].br; br_op = tbl[i].op;
            rs1 = tbl[i].a; rs2 = tbl[i].b; imm = tbl[i].im;
            jal = tbl[i].j; jalr = tbl[i].jr; trap_req = tbl[i].tr; mret = tbl[i].mr;
            @(negedge clk);
            chk($sformatf("tbl%0d_taken", i), taken, tbl[i].tk);
            chk($sformatf("tbl%0d_link", i), link, exp_pc + 4);
            tick();
            chk($sformatf("tbl%0d_pc", i), pc_out, tbl[i].pc);
            chk($sformatf("tbl%0d_epc", i), epc, tbl[i].epc);
            exp_pc = tbl[i].pc;
        end

        idle_in(); jal = 1; imm = 32'hFFFFFF60;
        tick(); chk("a_pc80", pc_out, 32'h80);
        idle_in(); pc_ready = 0; trap_req = 1;
        tick(); trap_req = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("a_pend_taken", taken, 1);
            tick();
            chk("a_pend_pc", pc_out, 32'h80); chk("a_pend_valid", pc_valid, 1);
        end
        pc_ready = 1;
        tick(); chk("a_trap_pc", pc_out, TRAP); chk("a_trap_epc", epc, 32'h80);
        mret = 1;
        tick(); chk("a_mret_pc", pc_out, 32'h80);

        idle_in(); jal = 1; imm = 32'hFFFFFF7C;
        tick(); chk("b_top_pc", pc_out, 32'hFFFFFFFC); chk("b_top_link", link, 0);
        idle_in();
        tick(); chk("b_wrap_pc", pc_out, 0);
        stall = 1; jal = 1; imm = 32'h40;
        tick(); chk("b_stall1", pc_out, 0);
        tick(); chk("b_stall2", pc_out, 0);
        idle_in();
        tick(); chk("b_after_stall", pc_out, 4);

        pc_ready = 0; trap_req = 1;
        tick(); trap_req = 0;
        #2 rst_n = 0;
        #1;
        chk("c_rst_pc", pc_out, 0); chk("c_rst_valid", pc_valid, 0);
        chk("c_rst_epc", epc, 0); chk("c_rst_taken", taken, 0);
        @(negedge clk) rst_n = 1; pc_ready = 1;
        tick(); chk("c_rel_valid", pc_valid, 1); chk("c_rel_pc", pc_out, 0);
        tick(); chk("c_no_trap_pc", pc_out, 4); chk("c_no_trap_epc", epc, 0);

        idle_in();
        rst_n = 0; m_reset();
        #3 rst_n = 1;
        for (int n = 0; n < 3000; n++) begin
            pc_ready = $urandom_range(0, 7) != 0;
            stall    = $urandom_range(0, 7) == 0;
            br_en    = $urandom_range(0, 2) == 0;
            br_op    = 3'($urandom);
            rs1      = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 15)) : $urandom;
            rs2      = $urandom_range(0, 3) == 0 ? rs1 : $urandom;
            imm      = 32'(($urandom_range(0, 255) - 128) * 4) + ($urandom_range(0, 7) == 0 ? 32'($urandom_range(1, 3)) : 0);
            jal      = $urandom_range(0, 7) == 0;
            jalr     = $urandom_range(0, 7) == 0;
            mret     = $urandom_range(0, 15) == 0;
            trap_req = $urandom_range(0, 19) == 0;
            @(negedge clk);
            chk("r_taken", taken, m_taken());
            chk("r_link", link, m_pc + 4);
            chk("r_valid", pc_valid, m_valid);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 0;
                #1 m_reset();
                chk("r_rst_pc", pc_out, 0);
                chk("r_rst_valid", pc_valid, 0);
                rst_n = 1;
            end
            @(posedge clk);
            m_edge();
            #1;
            chk("r_pc", pc_out, m_pc);
            chk("r_epc", epc, m_epc);
            chk("r_mis", misalign_err, m_mis);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
